// File: rtl/cam_pkg.sv
// cam_pkg: capture FSM state type and RGB565 -> RGB332 bit mapping
// shared by the camera capture block and its bench.
package cam_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VSYNC,
        CAPTURE,
        DONE
    } cam_state_t;

    // Bit positions inside the two RGB565 bytes (high byte b1, low byte b2)
    localparam int R_HI = 7;
    localparam int R_LO = 5;
    localparam int G_HI = 2;
    localparam int G_LO = 0;
    localparam int B_HI = 4;
    localparam int B_LO = 3;

    function automatic logic [7:0] rgb565_to_332(
        input logic [7:0] b1,
        input logic [7:0] b2
    );
        return {b1[R_HI:R_LO], b1[G_HI:G_LO], b2[B_HI:B_LO]};
    endfunction

endpackage

// File: rtl/cam_sync.sv
// cam_sync: 2-flop synchronizers for the camera bus plus a pclk
// rising-edge detector; data rides alongside the control bits.
module cam_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic       pclk,
    input  logic       vsync,
    input  logic       href,
    input  logic [7:0] data,
    output logic       pclk_rise,
    output logic       vsync_s,
    output logic       href_s,
    output logic [7:0] data_s
);

    logic [2:0] pclk_q;
    logic [1:0] vsync_q;
    logic [1:0] href_q;
    logic [7:0] data_q1;
    logic [7:0] data_q2;

    always_ff @(posedge clk) begin
        if (rst) begin
            pclk_q  <= '0;
            vsync_q <= '0;
            href_q  <= '0;
            data_q1 <= '0;
            data_q2 <= '0;
        end else begin
            pclk_q  <= {pclk_q[1:0], pclk};
            vsync_q <= {vsync_q[0], vsync};
            href_q  <= {href_q[0], href};
            data_q1 <= data;
            data_q2 <= data_q1;
        end
    end

    assign pclk_rise = pclk_q[1] & ~pclk_q[2];
    assign vsync_s   = vsync_q[1];
    assign href_s    = href_q[1];
    assign data_s    = data_q2;

endmodule

// File: rtl/cam_capture.sv
// cam_capture: RGB565 camera bus to RGB332 frame-buffer writer.
// Optional sticky err output when CAM_CAPTURE_ERR_EN is defined.
import cam_pkg::*;

module cam_capture #(
    parameter int H_RES  = 160,
    parameter int V_RES  = 120,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cam_pclk,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    input  logic              capture_en,
    output logic [7:0]        pix_data,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              pix_we,
    output logic              frame_done,
    output logic              busy
`ifdef CAM_CAPTURE_ERR_EN
    ,
    output logic              err
`endif
);

    localparam logic [31:0] TOTAL = 32'(H_RES * V_RES);

    cam_state_t state;

    logic       pclk_rise;
    logic       vsync_s;
    logic       href_s;
    logic [7:0] data_s;

    logic       vsync_q;
    logic       href_q;
    logic       phase;
    logic [7:0] b1;

    logic       vs_fall;
    logic       vs_rise;
    logic       hr_rise;
    logic       byte_ok;
    logic       phase_eff;
    logic       addr_ok;

    cam_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .pclk      (cam_pclk),
        .vsync     (cam_vsync),
        .href      (cam_href),
        .data      (cam_data),
        .pclk_rise (pclk_rise),
        .vsync_s   (vsync_s),
        .href_s    (href_s),
        .data_s    (data_s)
    );

    assign vs_fall   = pclk_rise & vsync_q & ~vsync_s;
    assign vs_rise   = pclk_rise & ~vsync_q & vsync_s;
    assign hr_rise   = pclk_rise & ~href_q & href_s;
    assign byte_ok   = pclk_rise & href_s;
    // A new line always starts on the high byte
    assign phase_eff = hr_rise ? 1'b0 : phase;
    assign addr_ok   = (32'(pix_addr) < TOTAL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pix_data   <= '0;
            pix_addr   <= '0;
            pix_we     <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            phase      <= 1'b0;
            b1         <= '0;
            vsync_q    <= 1'b0;
            href_q     <= 1'b0;
        end else begin
            pix_we     <= 1'b0;
            frame_done <= 1'b0;
            if (pix_we && pix_addr != '1) begin
                pix_addr <= pix_addr + 1'b1;
            end
            if (pclk_rise) begin
                vsync_q <= vsync_s;
                href_q  <= href_s;
            end
            unique case (state)
                IDLE: begin
                    if (capture_en) begin
                        state <= WAIT_VSYNC;
                        busy  <= 1'b1;
                    end
                end
                WAIT_VSYNC: begin
                    if (vs_fall) begin
                        state    <= CAPTURE;
                        pix_addr <= '0;
                        phase    <= 1'b0;
                    end
                end
                CAPTURE: begin
                    // Frame end wins over a byte sampled on the same edge
                    if (vs_rise) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end else if (byte_ok) begin
                        phase <= ~phase_eff;
                        if (!phase_eff) begin
                            b1 <= data_s;
                        end else if (addr_ok) begin
                            pix_we   <= 1'b1;
                            pix_data <= rgb565_to_332(b1, data_s);
                        end
                    end
                end
                DONE: begin
                    state <= capture_en ? WAIT_VSYNC : IDLE;
                    busy  <= capture_en;
                end
            endcase
        end
    end

`ifdef CAM_CAPTURE_ERR_EN
    localparam int LW = $clog2(H_RES + 1);

    logic [LW-1:0] line_pix;
    logic          pix_byte;

    assign pix_byte = byte_ok & phase_eff & ~vs_rise & (state == CAPTURE);

    always_ff @(posedge clk) begin
        if (rst) begin
            err      <= 1'b0;
            line_pix <= '0;
        end else begin
            if (hr_rise) begin
                line_pix <= '0;
            end else if (pix_byte) begin
                if (line_pix == LW'(H_RES)) begin
                    err <= 1'b1;
                end else begin
                    line_pix <= line_pix + 1'b1;
                end
            end
            if (pix_byte && !addr_ok) begin
                err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cam_capture.sv
// tb_cam_capture: random camera frames against a queue-based model of
// the expected frame-buffer writes.
module tb_cam_capture;

    localparam int H     = 4;
    localparam int V     = 2;
    localparam int AW    = 4;
    localparam int TOTAL = H * V;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cam_pclk = 1'b0;
    logic          cam_vsync = 1'b0;
    logic          cam_href = 1'b0;
    logic [7:0]    cam_data = '0;
    logic          capture_en = 1'b0;
    logic [7:0]    pix_data;
    logic [AW-1:0] pix_addr;
    logic          pix_we;
    logic          frame_done;
    logic          busy;
`ifdef CAM_CAPTURE_ERR_EN
    logic          err;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int fd_cnt   = 0;
    int exp_fd   = 0;
    int m_addr   = 0;
    bit exp_err  = 1'b0;
    bit model_on = 1'b1;
    int exp_q[$];

    cam_capture #(
        .H_RES  (H),
        .V_RES  (V),
        .ADDR_W (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cam_pclk   (cam_pclk),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_data   (cam_data),
        .capture_en (capture_en),
        .pix_data   (pix_data),
        .pix_addr   (pix_addr),
        .pix_we     (pix_we),
        .frame_done (frame_done),
        .busy       (busy)
`ifdef CAM_CAPTURE_ERR_EN
        ,
        .err        (err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int e;
    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt++;
        if (pix_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("we_unexp", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("addr", 32'(pix_addr), 32'(e >> 8));
                check("data", 32'(pix_data), 32'(e & 8'hff));
            end
        end
    end

    // One camera byte: pclk low for 2 clk, high for 2 clk (clk/4)
    task automatic tick(input bit vs, input bit hr, input logic [7:0] d);
        @(negedge clk);
        cam_pclk  = 1'b0;
        cam_vsync = vs;
        cam_href  = hr;
        cam_data  = d;
        @(negedge clk);
        @(negedge clk);
        cam_pclk = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_line(input int nb, input bit fixed, input bit vs_last);
        logic [7:0] b;
        logic [7:0] hb;
        logic [7:0] px;
        int npix;
        npix = 0;
        hb = '0;
        for (int i = 0; i < nb; i++) begin
            if (fixed) b = (i % 2 == 0) ? 8'hF8 : 8'h1F;
            else b = 8'($urandom);
            if (vs_last && i == nb - 1) begin
                tick(1'b1, 1'b1, b);
            end else begin
                if (i % 2 == 0) begin
                    hb = b;
                end else if (model_on) begin
                    npix++;
                    if (npix > H) exp_err = 1'b1;
                    px = {hb[7:5], hb[2:0], b[4:3]};
                    if (m_addr < TOTAL) begin
                        exp_q.push_back((m_addr << 8) | int'(px));
                        m_addr++;
                    end else begin
                        exp_err = 1'b1;
                    end
                end
                tick(1'b0, 1'b1, b);
            end
        end
        if (!vs_last) tick(1'b0, 1'b0, 8'h00);
    endtask

    task automatic frame_checks();
        repeat (6) @(negedge clk);
        check("fd_cnt", fd_cnt, exp_fd);
        check("drain", exp_q.size(), 0);
        check("addr_end", 32'(pix_addr), m_addr);
`ifdef CAM_CAPTURE_ERR_EN
        check("err", 32'(err), 32'(exp_err));
`endif
    endtask

    task automatic do_frame(
        input int nlines,
        input int nb,
        input bit fixed,
        input bit vs_last,
        input bit drop_en
    );
        tick(1'b1, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 8'h00);
        m_addr = 0;
        tick(1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 8'h00);
        check("busy_cap", 32'(busy), 32'd1);
        for (int l = 0; l < nlines; l++) begin
            if (drop_en && l == 1) capture_en = 1'b0;
            send_line(nb, fixed, vs_last && l == nlines - 1);
        end
        if (!vs_last) tick(1'b1, 1'b0, 8'h00);
        exp_fd++;
        frame_checks();
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", 32'(pix_data), 32'd0);
        check("rst_addr", 32'(pix_addr), 32'd0);
        check("rst_we", 32'(pix_we), 32'd0);
        check("rst_fd", 32'(frame_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        capture_en = 1'b1;
        repeat (3) @(negedge clk);
        check("busy_wait", 32'(busy), 32'd1);

        do_frame(2, 8, 1'b1, 1'b0, 1'b0);
        do_frame(2, 9, 1'b0, 1'b0, 1'b0);
        do_frame(3, 8, 1'b0, 1'b0, 1'b0);
        do_frame(2, 8, 1'b0, 1'b1, 1'b0);
        for (int f = 0; f < 20; f++) begin
            do_frame(2, 8, 1'b0, 1'b0, 1'b0);
        end

        do_frame(2, 8, 1'b0, 1'b0, 1'b1);
        check("busy_idle", 32'(busy), 32'd0);

        // vsync activity while idle must not start a frame
        model_on = 1'b0;
        tick(1'b1, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 8'h00);
        send_line(8, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 8'h00);
        repeat (6) @(negedge clk);
        check("idle_fd", fd_cnt, exp_fd);
        check("idle_busy", 32'(busy), 32'd0);
        model_on = 1'b1;

        // Reset in the middle of a line
        capture_en = 1'b1;
        tick(1'b1, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 8'h00);
        exp_q.push_back(8'hE3);
        tick(1'b0, 1'b1, 8'hF8);
        tick(1'b0, 1'b1, 8'h1F);
        tick(1'b0, 1'b1, 8'hF8);
        repeat (4) @(negedge clk);
        check("pre_rst_drain", exp_q.size(), 0);
        capture_en = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("mrst_data", 32'(pix_data), 32'd0);
        check("mrst_addr", 32'(pix_addr), 32'd0);
        check("mrst_we", 32'(pix_we), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
`ifdef CAM_CAPTURE_ERR_EN
        check("mrst_err", 32'(err), 32'd0);
`endif
        rst = 1'b0;
        model_on = 1'b0;
        tick(1'b0, 1'b1, 8'h1F);
        tick(1'b1, 1'b0, 8'h00);
        repeat (6) @(negedge clk);
        check("mrst_fd", fd_cnt, exp_fd);
        check("mrst_drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
